// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multi-cycle multiplier/divider: launches a mult/div
// from D/X, tracks it to completion (or timeout) and holds the result for writeback.
module multdiv_ctrl #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int RSTATUS_REG    = 30,
    parameter int MULT_EXC_CODE  = 4,
    parameter int DIV_EXC_CODE   = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_ir_in,
    input  logic [31:0] dx_operand_a,
    input  logic [31:0] dx_operand_b,
    input  logic [31:0] data_result,
    input  logic        data_exception,
    input  logic        data_resultRDY,
    input  logic        wb_accept,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] data_operandA,
    output logic [31:0] data_operandB,
    output logic        multdiv_launch,
    output logic        multdiv_is_running,
    output logic        multdiv_result_ready,
    output logic [31:0] result_value,
    output logic [4:0]  result_rd,
    output logic        result_exception
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MULT  = 5'b00110;
    localparam logic [4:0] ALU_DIV   = 5'b00111;

    logic [1:0]       state_reg, state_next;
    logic             op_div_reg, op_div_next;
    logic [4:0]       rd_reg, rd_next;
    logic [31:0]      operand_a_reg, operand_a_next;
    logic [31:0]      operand_b_reg, operand_b_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [31:0]      result_value_reg, result_value_next;
    logic [4:0]       result_rd_reg, result_rd_next;
    logic             result_exception_reg, result_exception_next;

    logic is_rtype, is_mult, is_div, timeout_hit;
    logic unused_ir_bits;

    assign is_rtype    = (dx_ir_in[31:27] == OPC_RTYPE);
    assign is_mult     = is_rtype && (dx_ir_in[6:2] == ALU_MULT);
    assign is_div      = is_rtype && (dx_ir_in[6:2] == ALU_DIV);
    assign timeout_hit = (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign unused_ir_bits = ^{dx_ir_in[21:7], dx_ir_in[1:0]};

    always_comb begin
        state_next            = state_reg;
        op_div_next           = op_div_reg;
        rd_next               = rd_reg;
        operand_a_next        = operand_a_reg;
        operand_b_next        = operand_b_reg;
        count_next            = count_reg;
        result_value_next     = result_value_reg;
        result_rd_next        = result_rd_reg;
        result_exception_next = result_exception_reg;
        case (state_reg)
            ST_IDLE: begin
                if (is_mult || is_div) begin
                    state_next     = ST_START;
                    op_div_next    = is_div;
                    rd_next        = dx_ir_in[26:22];
                    operand_a_next = dx_operand_a;
                    operand_b_next = dx_operand_b;
                end
            end
            ST_START: begin
                count_next = '0;
                state_next = ST_BUSY;
            end
            ST_BUSY: begin
                count_next = count_reg + CNT_W'(1);
                // A completion strobe outranks a timeout landing on the same cycle.
                if (data_resultRDY && !data_exception) begin
                    result_value_next     = data_result;
                    result_rd_next        = rd_reg;
                    result_exception_next = 1'b0;
                    state_next            = ST_DONE;
                end else if (data_resultRDY || timeout_hit) begin
                    result_value_next     = op_div_reg ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
                    result_rd_next        = 5'(RSTATUS_REG);
                    result_exception_next = 1'b1;
                    state_next            = ST_DONE;
                end
            end
            default: begin
                if (wb_accept) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg            <= ST_IDLE;
            op_div_reg           <= 1'b0;
            rd_reg               <= '0;
            operand_a_reg        <= '0;
            operand_b_reg        <= '0;
            count_reg            <= '0;
            result_value_reg     <= '0;
            result_rd_reg        <= '0;
            result_exception_reg <= 1'b0;
        end else begin
            state_reg            <= state_next;
            op_div_reg           <= op_div_next;
            rd_reg               <= rd_next;
            operand_a_reg        <= operand_a_next;
            operand_b_reg        <= operand_b_next;
            count_reg            <= count_next;
            result_value_reg     <= result_value_next;
            result_rd_reg        <= result_rd_next;
            result_exception_reg <= result_exception_next;
        end
    end

    assign multdiv_launch       = (state_reg == ST_IDLE) && (is_mult || is_div);
    assign ctrl_MULT            = (state_reg == ST_START) && !op_div_reg;
    assign ctrl_DIV             = (state_reg == ST_START) && op_div_reg;
    assign multdiv_is_running   = (state_reg != ST_IDLE);
    assign multdiv_result_ready = (state_reg == ST_DONE);
    assign data_operandA        = operand_a_reg;
    assign data_operandB        = operand_b_reg;
    assign result_value         = result_value_reg;
    assign result_rd            = result_rd_reg;
    assign result_exception     = result_exception_reg;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl: one task per scenario, with
// hand-computed expectations checked inline.
module tb_multdiv_ctrl;

    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dx_ir_in = '0;
    logic [31:0] dx_operand_a = '0;
    logic [31:0] dx_operand_b = '0;
    logic [31:0] data_result = '0;
    logic        data_exception = 1'b0;
    logic        data_resultRDY = 1'b0;
    logic        wb_accept = 1'b0;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic        multdiv_launch, multdiv_is_running, multdiv_result_ready;
    logic [31:0] result_value;
    logic [4:0]  result_rd;
    logic        result_exception;

    int errors = 0;
    int checks = 0;

    multdiv_ctrl dut (
        .clock(clock), .reset(reset), .dx_ir_in(dx_ir_in),
        .dx_operand_a(dx_operand_a), .dx_operand_b(dx_operand_b),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .wb_accept(wb_accept),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .multdiv_launch(multdiv_launch), .multdiv_is_running(multdiv_is_running),
        .multdiv_result_ready(multdiv_result_ready), .result_value(result_value),
        .result_rd(result_rd), .result_exception(result_exception)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [4:0] rd,
                                          input logic [4:0] alu);
        return {opc, rd, 15'b0, alu, 2'b00};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({ctrl_MULT, ctrl_DIV, multdiv_launch, multdiv_is_running, multdiv_result_ready,
             result_exception} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000", {ctrl_MULT, ctrl_DIV,
                     multdiv_launch, multdiv_is_running, multdiv_result_ready, result_exception});
        end
        checks++;
        if ({data_operandA, data_operandB, result_value, result_rd} !== 101'b0) begin
            errors++;
            $display("FAIL reset_data: opA=%h opB=%h val=%h rd=%0d want all 0",
                     data_operandA, data_operandB, result_value, result_rd);
        end
        $display("test_reset done");
    endtask

    task automatic test_mult();
        int pulses = 0;
        int run_low = 0;
        dx_ir_in = mk_ir(5'b0, 5'd3, 5'b00110);
        dx_operand_a = 32'd7;
        dx_operand_b = 32'd6;
        #1;
        checks++;
        if (multdiv_launch !== 1'b1) begin
            errors++;
            $display("FAIL mult_launch: got %b want 1", multdiv_launch);
        end
        step();
        dx_ir_in = '0;
        if (ctrl_MULT === 1'b1) pulses++;
        checks++;
        if (data_operandA !== 32'd7 || data_operandB !== 32'd6 || ctrl_DIV !== 1'b0) begin
            errors++;
            $display("FAIL mult_start: opA=%0d opB=%0d div=%b want 7 6 0",
                     data_operandA, data_operandB, ctrl_DIV);
        end
        for (int i = 1; i <= 17; i++) begin
            step();
            if (ctrl_MULT === 1'b1) pulses++;
            if (multdiv_is_running !== 1'b1 || multdiv_result_ready !== 1'b0) run_low++;
            if (i == 17) begin
                data_resultRDY = 1'b1;
                data_result = 32'd42;
            end
        end
        step();
        data_resultRDY = 1'b0;
        data_result = '0;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL mult_pulse_len: got %0d cycles want 1", pulses);
        end
        checks++;
        if (run_low != 0) begin
            errors++;
            $display("FAIL mult_running: got %0d bad cycles want 0", run_low);
        end
        checks++;
        if (multdiv_result_ready !== 1'b1 || result_value !== 32'd42 || result_rd !== 5'd3
            || result_exception !== 1'b0 || multdiv_is_running !== 1'b1) begin
            errors++;
            $display("FAIL mult_done: rdy=%b val=%0d rd=%0d exc=%b run=%b want 1 42 3 0 1",
                     multdiv_result_ready, result_value, result_rd, result_exception,
                     multdiv_is_running);
        end
        wb_accept = 1'b1;
        step();
        wb_accept = 1'b0;
        checks++;
        if (multdiv_is_running !== 1'b0 || multdiv_result_ready !== 1'b0) begin
            errors++;
            $display("FAIL mult_idle: run=%b rdy=%b want 0 0", multdiv_is_running,
                     multdiv_result_ready);
        end
        $display("test_mult done: result=%0d rd=%0d", result_value, result_rd);
    endtask

    task automatic test_divzero();
        dx_ir_in = mk_ir(5'b0, 5'd5, 5'b00111);
        dx_operand_a = 32'd9;
        dx_operand_b = 32'd0;
        step();
        dx_ir_in = '0;
        checks++;
        if (ctrl_DIV !== 1'b1 || ctrl_MULT !== 1'b0) begin
            errors++;
            $display("FAIL div_pulse: div=%b mult=%b want 1 0", ctrl_DIV, ctrl_MULT);
        end
        step();
        step();
        data_resultRDY = 1'b1;
        data_exception = 1'b1;
        data_result = 32'hDEAD_BEEF;
        step();
        data_resultRDY = 1'b0;
        data_exception = 1'b0;
        data_result = '0;
        checks++;
        if (multdiv_result_ready !== 1'b1 || result_rd !== 5'd30 || result_value !== 32'd5
            || result_exception !== 1'b1) begin
            errors++;
            $display("FAIL div_exc: rdy=%b rd=%0d val=%0d exc=%b want 1 30 5 1",
                     multdiv_result_ready, result_rd, result_value, result_exception);
        end
        wb_accept = 1'b1;
        step();
        wb_accept = 1'b0;
        $display("test_divzero done: status=%0d rd=%0d", result_value, result_rd);
    endtask

    task automatic test_timeout();
        int busy = 0;
        bit got = 0;
        dx_ir_in = mk_ir(5'b0, 5'd7, 5'b00110);
        step();
        dx_ir_in = '0;
        for (int i = 0; i < 100 && !got; i++) begin
            step();
            if (multdiv_result_ready === 1'b1) got = 1;
            else busy++;
        end
        checks++;
        if (!got || busy != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_len: done=%0d busy=%0d want 1 %0d", got, busy, TIMEOUT);
        end
        checks++;
        if (result_rd !== 5'd30 || result_value !== 32'd4 || result_exception !== 1'b1) begin
            errors++;
            $display("FAIL timeout_exc: rd=%0d val=%0d exc=%b want 30 4 1",
                     result_rd, result_value, result_exception);
        end
        wb_accept = 1'b1;
        step();
        wb_accept = 1'b0;
        // Completion strobe landing on the last BUSY cycle must beat the timeout.
        dx_ir_in = mk_ir(5'b0, 5'd9, 5'b00110);
        step();
        dx_ir_in = '0;
        for (int i = 0; i < TIMEOUT; i++) step();
        data_resultRDY = 1'b1;
        data_result = 32'd99;
        step();
        data_resultRDY = 1'b0;
        data_result = '0;
        checks++;
        if (multdiv_result_ready !== 1'b1 || result_value !== 32'd99 || result_rd !== 5'd9
            || result_exception !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rdy_wins: rdy=%b val=%0d rd=%0d exc=%b want 1 99 9 0",
                     multdiv_result_ready, result_value, result_rd, result_exception);
        end
        wb_accept = 1'b1;
        step();
        wb_accept = 1'b0;
        $display("test_timeout done: busy_cycles=%0d", busy);
    endtask

    task automatic test_backpressure();
        int bad = 0;
        dx_ir_in = mk_ir(5'b0, 5'd3, 5'b00110);
        dx_operand_a = 32'd7;
        dx_operand_b = 32'd6;
        step();
        dx_ir_in = '0;
        step();
        step();
        data_resultRDY = 1'b1;
        data_result = 32'd42;
        step();
        data_resultRDY = 1'b0;
        data_result = '0;
        for (int i = 0; i < 10; i++) begin
            if (multdiv_result_ready !== 1'b1 || result_value !== 32'd42
                || result_rd !== 5'd3 || result_exception !== 1'b0) bad++;
            if (i == 4) begin
                data_resultRDY = 1'b1;
                data_exception = 1'b1;
                data_result = 32'h1234;
            end
            step();
            data_resultRDY = 1'b0;
            data_exception = 1'b0;
            data_result = '0;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
        end
        checks++;
        if (multdiv_result_ready !== 1'b1 || result_value !== 32'd42) begin
            errors++;
            $display("FAIL hold_end: rdy=%b val=%0d want 1 42", multdiv_result_ready,
                     result_value);
        end
        wb_accept = 1'b1;
        step();
        wb_accept = 1'b0;
        checks++;
        if (multdiv_is_running !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: run=%b want 0", multdiv_is_running);
        end
        $display("test_backpressure done: held result=%0d", result_value);
    endtask

    task automatic test_back_to_back();
        int early = 0;
        dx_ir_in = mk_ir(5'b0, 5'd2, 5'b00110);
        step();
        dx_ir_in = '0;
        step();
        data_resultRDY = 1'b1;
        data_result = 32'd11;
        step();
        data_resultRDY = 1'b0;
        dx_ir_in = mk_ir(5'b0, 5'd6, 5'b00111);
        dx_operand_a = 32'd100;
        dx_operand_b = 32'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (multdiv_launch !== 1'b0 || ctrl_DIV !== 1'b0 || multdiv_result_ready !== 1'b1)
                early++;
            step();
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL b2b_no_early: got %0d early cycles want 0", early);
        end
        wb_accept = 1'b1;
        step();
        wb_accept = 1'b0;
        checks++;
        if (multdiv_launch !== 1'b1 || multdiv_is_running !== 1'b0) begin
            errors++;
            $display("FAIL b2b_launch: launch=%b run=%b want 1 0", multdiv_launch,
                     multdiv_is_running);
        end
        step();
        dx_ir_in = '0;
        checks++;
        if (ctrl_DIV !== 1'b1 || data_operandA !== 32'd100 || data_operandB !== 32'd3) begin
            errors++;
            $display("FAIL b2b_start: div=%b opA=%0d opB=%0d want 1 100 3", ctrl_DIV,
                     data_operandA, data_operandB);
        end
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (multdiv_is_running !== 1'b0 || multdiv_result_ready !== 1'b0
            || ctrl_DIV !== 1'b0 || ctrl_MULT !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: run=%b rdy=%b div=%b mult=%b want 0 0 0 0",
                     multdiv_is_running, multdiv_result_ready, ctrl_DIV, ctrl_MULT);
        end
        checks++;
        if ({data_operandA, data_operandB, result_value, result_rd, result_exception} !== 102'b0)
        begin
            errors++;
            $display("FAIL midreset_data: opA=%h opB=%h val=%h rd=%0d exc=%b want all 0",
                     data_operandA, data_operandB, result_value, result_rd, result_exception);
        end
        data_resultRDY = 1'b1;
        data_result = 32'd77;
        step();
        data_resultRDY = 1'b0;
        data_result = '0;
        checks++;
        if (multdiv_result_ready !== 1'b0 || result_value !== 32'd0) begin
            errors++;
            $display("FAIL midreset_drop: rdy=%b val=%0d want 0 0", multdiv_result_ready,
                     result_value);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_nonmultdiv();
        logic [31:0] irs [3];
        int bad = 0;
        irs[0] = mk_ir(5'b00000, 5'd4, 5'b00000);
        irs[1] = mk_ir(5'b01000, 5'd4, 5'b00110);
        irs[2] = mk_ir(5'b00101, 5'd4, 5'b00111);
        for (int k = 0; k < 3; k++) begin
            dx_ir_in = irs[k];
            for (int i = 0; i < 3; i++) begin
                #1;
                if (multdiv_launch !== 1'b0) bad++;
                step();
                if (ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0 || multdiv_is_running !== 1'b0)
                    bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL nonmultdiv_%0d: got %0d bad cycles want 0", k, bad);
            end
            bad = 0;
        end
        dx_ir_in = '0;
        $display("test_nonmultdiv done");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divzero();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_nonmultdiv();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
